// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg
//   Types and constants shared by the instruction-fetch prefetch block.
//   fetch_entry_t : one prefetch-queue entry {pc, instr}
//   PC_INC        : fetch address increment (one 32-bit instruction word)
//   align_word()  : clears the byte-offset bits of a redirect target
package if_prefetch_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [XLEN_DEF-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN_DEF-1:0] align_word(input logic [XLEN_DEF-1:0] pc);
    return {pc[XLEN_DEF-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/imem_sync.sv
// imem_sync
//   2^AW x XLEN instruction ROM with a registered (one-cycle) read.
//   The array is loaded from the program hex image by the integrating
//   environment; the fetch path only ever reads it.
//   clk   : clock
//   en    : read strobe, data appears on rdata after the next rising edge
//   addr  : word address (wraps naturally at 2^AW words)
//   rdata : registered read data
module imem_sync #(
  parameter int XLEN = 32,
  parameter int AW   = 10
) (
  input  logic            clk,
  input  logic            en,
  input  logic [AW-1:0]   addr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch
//   Instruction prefetch: issues sequential fetches into a one-cycle ROM and
//   buffers the responses in a DEPTH-entry queue ahead of decode.
//   clk            : clock
//   reset          : asynchronous active-low reset
//   PCSrc          : redirect request, fetch restarts at PC_Branch
//   PC_Branch      : redirect target (byte offset ignored)
//   PC_write       : fetch enable
//   ready_ID       : decode accepts the head entry
//   valid_IF       : head entry present
//   PC_IF          : PC of head entry (0 when empty)
//   INSTRUCTION_IF : instruction of head entry (0 when empty)
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              IMEM_AW  = 10,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PC_Branch,
  input  logic            PC_write,
  input  logic            ready_ID,
  output logic            valid_IF,
  output logic [XLEN-1:0] PC_IF,
  output logic [XLEN-1:0] INSTRUCTION_IF
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    q [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;

  logic [XLEN-1:0] branch_pc;
  logic [XLEN-1:0] issue_pc;
  logic [XLEN-1:0] rdata;
  logic [CW:0]     occupancy;
  logic            pop;
  logic            issue;
  logic            unused_pc_bits;

  assign branch_pc = align_word(PC_Branch);
  assign valid_IF  = (count != '0);
  assign pop       = valid_IF & ready_ID & ~PCSrc;

  // Entries held plus the response already on its way, after this edge's pop.
  // Issuing only while this is below DEPTH reserves a slot for every response.
  assign occupancy = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);

  // A redirect discards everything, so there is always room for its fetch.
  assign issue    = PC_write & (PCSrc | (occupancy < (CW+1)'(DEPTH)));
  assign issue_pc = PCSrc ? branch_pc : fetch_pc;

  assign unused_pc_bits = ^{issue_pc[XLEN-1:IMEM_AW+2], issue_pc[1:0]};

  imem_sync #(
    .XLEN (XLEN),
    .AW   (IMEM_AW)
  ) u_imem (
    .clk   (clk),
    .en    (issue),
    .addr  (issue_pc[IMEM_AW+1:2]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (PCSrc) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= PC_write;
      req_pc   <= branch_pc;
      fetch_pc <= PC_write ? branch_pc + PC_INC : branch_pc;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + PC_INC;
        req_pc   <= fetch_pc;
      end
      inflight <= issue;
      if (inflight) tail <= tail + PW'(1);
      if (pop)      head <= head + PW'(1);
      count <= count + CW'(inflight) - CW'(pop);
    end
  end

  // Storage needs no reset: count gates everything that is visible.
  always_ff @(posedge clk) begin
    if (inflight && !PCSrc) q[tail] <= '{pc: req_pc, instr: rdata};
  end

  assign PC_IF          = valid_IF ? q[head].pc    : '0;
  assign INSTRUCTION_IF = valid_IF ? q[head].instr : '0;

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;

  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PC_Branch = '0;
  logic        PC_write = 1'b0;
  logic        ready_ID = 1'b0;
  logic        valid_IF;
  logic [31:0] PC_IF;
  logic [31:0] INSTRUCTION_IF;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  if_prefetch #(
    .XLEN     (32),
    .IMEM_AW  (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .PCSrc          (PCSrc),
    .PC_Branch      (PC_Branch),
    .PC_write       (PC_write),
    .ready_ID       (ready_ID),
    .valid_IF       (valid_IF),
    .PC_IF          (PC_IF),
    .INSTRUCTION_IF (INSTRUCTION_IF)
  );

  // ROM[i] = 0x100 + i; the 16-word ROM aliases higher PCs.
  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'h100 + {28'h0, pc[5:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  // Called at a falling edge with inputs settled: if the head will be
  // consumed on the coming rising edge, compare it against the scoreboard.
  task automatic tick();
    logic [31:0] e;
    if (valid_IF && ready_ID && !PCSrc) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_extra: observed pc %h expected no entry", PC_IF);
      end else begin
        e = sb.pop_front();
        check("pop_pc", PC_IF, e);
        check("pop_instr", INSTRUCTION_IF, exp_instr(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dut.u_imem.mem[i] = 32'h100 + 32'(i);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid_IF), 32'd0);
    check("rst_pc", PC_IF, 32'h0);
    check("rst_instr", INSTRUCTION_IF, 32'h0);

    // first fetch after release: visible after the second edge
    PC_write = 1'b1; ready_ID = 1'b1; reset = 1'b1;
    push_run(32'h0, 2);
    tick();
    check("t1_lat_valid", 32'(valid_IF), 32'd0);
    tick();
    check("t1_valid", 32'(valid_IF), 32'd1);
    check("t1_pc", PC_IF, 32'h0);
    check("t1_instr", INSTRUCTION_IF, 32'h100);
    tick();
    tick();
    check("t1_pc_seq", PC_IF, 32'h8);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // decode stall: queue fills to DEPTH, then drains without a gap
    PCSrc = 1'b1; PC_Branch = 32'h0; ready_ID = 1'b0;
    sb.delete();
    push_run(32'h0, 5);
    tick();
    PCSrc = 1'b0;
    repeat (10) tick();
    check("t2_count", 32'(dut.count), 32'd4);
    check("t2_inflight", 32'(dut.inflight), 32'd0);
    check("t2_head_pc", PC_IF, 32'h0);
    ready_ID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t2_nogap", 32'(valid_IF), 32'd1);
      tick();
    end
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // flush of a full queue by a redirect to an unaligned target
    PCSrc = 1'b1; PC_Branch = 32'h0; ready_ID = 1'b0;
    sb.delete();
    tick();
    PCSrc = 1'b0;
    repeat (6) tick();
    check("t3_full", 32'(dut.count), 32'd4);
    PCSrc = 1'b1; PC_Branch = 32'h41; ready_ID = 1'b1;
    sb.delete();
    push_run(32'h40, 4);
    tick();
    check("t3_flushed", 32'(valid_IF), 32'd0);
    PCSrc = 1'b0;
    tick();
    check("t3_pc", PC_IF, 32'h40);
    check("t3_instr", INSTRUCTION_IF, 32'h100);
    tick();
    tick();

    // fetch disabled while draining
    PC_write = 1'b0;
    repeat (3) tick();
    check("t4_valid", 32'(valid_IF), 32'd0);
    check("t4_pc", PC_IF, 32'h0);
    check("t4_instr", INSTRUCTION_IF, 32'h0);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    PC_write = 1'b1;
    push_run(32'h50, 2);
    tick();
    tick();
    check("t4_resume_pc", PC_IF, 32'h50);
    tick();
    tick();
    check("t4_sb_empty2", 32'(sb.size()), 32'd0);

    // asynchronous reset with a request in flight and two entries held
    ready_ID = 1'b0;
    tick();
    check("t5_pre_count", 32'(dut.count), 32'd2);
    check("t5_pre_inflight", 32'(dut.inflight), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_valid", 32'(valid_IF), 32'd0);
    check("t5_pc", PC_IF, 32'h0);
    check("t5_instr", INSTRUCTION_IF, 32'h0);
    check("t5_inflight", 32'(dut.inflight), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; ready_ID = 1'b1;
    sb.delete();
    push_run(32'h0, 3);
    tick();
    check("t5_lat_valid", 32'(valid_IF), 32'd0);
    tick();
    check("t5_restart_pc", PC_IF, 32'h0);
    repeat (3) tick();
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // redirect with fetch disabled: target held, nothing issued
    PCSrc = 1'b1; PC_write = 1'b0; PC_Branch = 32'h23;
    sb.delete();
    tick();
    PCSrc = 1'b0;
    tick();
    check("t6_noissue", 32'(valid_IF), 32'd0);
    check("t6_fetch_pc", dut.fetch_pc, 32'h20);
    PC_write = 1'b1;
    push_run(32'h20, 2);
    tick();
    tick();
    check("t6_pc", PC_IF, 32'h20);
    check("t6_instr", INSTRUCTION_IF, 32'h108);
    tick();
    tick();
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    // ROM aliasing past 2^AW words
    PCSrc = 1'b1; PC_Branch = 32'h3C;
    sb.delete();
    push_run(32'h3C, 2);
    tick();
    PCSrc = 1'b0;
    tick();
    check("t7_pc", PC_IF, 32'h3C);
    check("t7_instr", INSTRUCTION_IF, 32'h10F);
    tick();
    check("t7_alias_pc", PC_IF, 32'h40);
    check("t7_alias_instr", INSTRUCTION_IF, 32'h100);
    tick();
    check("t7_sb_empty", 32'(sb.size()), 32'd0);

    // fetch_pc wraps modulo 2^32
    PCSrc = 1'b1; PC_Branch = 32'hFFFF_FFFC;
    sb.delete();
    push_run(32'hFFFF_FFFC, 2);
    tick();
    PCSrc = 1'b0;
    tick();
    check("t8_pc", PC_IF, 32'hFFFF_FFFC);
    check("t8_instr", INSTRUCTION_IF, 32'h10F);
    tick();
    check("t8_wrap_pc", PC_IF, 32'h0);
    check("t8_wrap_instr", INSTRUCTION_IF, 32'h100);
    tick();
    check("t8_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter XLEN, 32, PC and instruction width in bits.
REQ-002 Parameter IMEM_AW, 10, instruction-memory word-address width (2^IMEM_AW words).
REQ-003 Parameter DEPTH, 4, prefetch-queue entries; power of two, 2..16.
REQ-004 Parameter RESET_PC, 0, fetch address loaded on reset.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 PCSrc  in  1  redirect request: 1 = fetch continues at PC_Branch.
REQ-008 PC_Branch  in  XLEN  redirect target.
REQ-009 PC_write  in  1  fetch enable; 0 = no new memory request is issued.
REQ-010 ready_ID  in  1  decode accepts head entry this cycle.
REQ-011 valid_IF  out  1  head entry present.
REQ-012 PC_IF  out  XLEN  PC of head entry.
REQ-013 INSTRUCTION_IF  out  XLEN  instruction of head entry.

Function
REQ-014 The block SHALL hold fetch_pc, a one-deep in-flight request flag, and a circular queue of DEPTH {pc, instruction} entries with head, tail and count (0..DEPTH).
REQ-015 Issue: a request SHALL be issued on an edge when PC_write=1 and count + inflight - pop < DEPTH, where pop = valid_IF & ready_ID.
REQ-016 An issued request SHALL present word address fetch_pc[IMEM_AW+1:2] to the memory; fetch_pc SHALL then advance by 4, modulo 2^XLEN.
REQ-017 Memory read latency SHALL be exactly one cycle; the response SHALL be pushed at the tail on the following edge with its request PC.
REQ-018 Pop SHALL advance head on an edge when valid_IF=1 and ready_ID=1; push and pop on the same edge SHALL leave count unchanged, including when count=DEPTH.
REQ-019 valid_IF SHALL equal (count != 0); PC_IF and INSTRUCTION_IF SHALL be 0 while valid_IF=0.
REQ-020 Redirect (PCSrc=1) SHALL, on that edge, empty the queue, discard any in-flight response, and ignore ready_ID.
REQ-021 On a redirect edge with PC_write=1, a request SHALL be issued to {PC_Branch[XLEN-1:2],2'b00} and fetch_pc SHALL become that address + 4; with PC_write=0, fetch_pc SHALL become that address and nothing is issued.
REQ-022 PC_Branch[1:0] SHALL be ignored (forced to 0).
REQ-023 Memory addressing SHALL wrap modulo 2^IMEM_AW words; PCs beyond the memory alias.
REQ-024 The queue SHALL never overflow; the issue rule (REQ-015) guarantees a slot for every in-flight response.
REQ-025 Minimum latency: the instruction at a new fetch_pc SHALL appear on valid_IF two edges after the issuing edge is preceded by reset release or redirect (issue edge + 1).

Reset
REQ-026 reset=0 SHALL asynchronously set fetch_pc=RESET_PC, count=0, head=tail=0, inflight=0; outputs valid_IF=0, PC_IF=0, INSTRUCTION_IF=0.
REQ-027 Reset asserted mid-fetch SHALL discard the in-flight response; memory contents SHALL be unaffected.
REQ-028 First request SHALL issue on the first rising edge after reset deasserts (PC_write=1).

Structure
REQ-029 A shared package SHALL hold the queue-entry typedef {pc, instruction} and the PC increment constant 4.
REQ-030 One sub-module, imem_sync, SHALL implement the 2^IMEM_AW x XLEN synchronous-read instruction ROM initialised from a hex file.
REQ-031 Queue pointers SHALL be $clog2(DEPTH) bits; count SHALL be $clog2(DEPTH)+1 bits.

Verification
REQ-032 Reset release, ready_ID=1, PC_write=1, ROM[i]=i+0x100 -> valid_IF rises after 2nd edge with PC_IF=0x0, INSTRUCTION_IF=0x100; then PC 0x4, 0x8 one per cycle.
REQ-033 ready_ID=0 for 10 cycles, DEPTH=4 -> count stalls at 4, no overflow; ready_ID=1 -> PCs 0x0,0x4,0x8,0xC then 0x10 without gap.
REQ-034 Queue holding 0x0..0xC, PCSrc=1 with PC_Branch=0x41 -> queue flushed, next valid_IF shows PC_IF=0x40 after one edge; stale 0x10 never appears.
REQ-035 PC_write=0 for 3 cycles while draining -> queue empties, valid_IF=0, outputs 0; PC_write=1 resumes at the held fetch_pc.
REQ-036 reset pulsed low mid-cycle with inflight=1 and count=2 -> outputs zero immediately; after release fetching restarts at RESET_PC.
REQ-037 IMEM_AW=4, fetch from 0x3C -> next PC 0x40 reads ROM[0]; fetch_pc 0xFFFFFFFC -> wraps to 0x0.
